// File: rtl/nn_act_pkg.sv
`default_nettype none
// ============================================================================
// nn_act_pkg : shared constants and tag type for the activation scheduler
// Revision   : 1.0
// ============================================================================
package nn_act_pkg;

  localparam int ACT_DW  = 16;
  localparam int ACT_IDW = 2;

  // Saturation words of the 16-bit float activation: +1.0 and -1.0
  localparam logic [ACT_DW-1:0] SIG_POS_SAT = 16'h3C00;
  localparam logic [ACT_DW-1:0] SIG_NEG_SAT = 16'hBC00;

  typedef struct packed {
    logic               vld;
    logic [ACT_IDW-1:0] id;
  } act_tag_t;

endpackage
`default_nettype wire

// File: rtl/act_result_fifo.sv
`default_nettype none
// ============================================================================
// act_result_fifo : power-of-2 result FIFO with occupancy count output
// Revision        : 1.0
// ============================================================================
module act_result_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // The issuer's credit scheme must make both of these impossible
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_push && (r_count == CW'(DEPTH))));
      assert (!(i_pop && (r_count == '0)));
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sigmoid_act_scheduler.sv
`default_nettype none
// ============================================================================
// sigmoid_act_scheduler : round-robin sharing of one activation unit among N
//                         requesters, with credit-protected result queueing
// Revision              : 1.0
// ============================================================================
module sigmoid_act_scheduler
  import nn_act_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int IDW        = ACT_IDW,
  parameter int DW         = ACT_DW,
  parameter int ACT_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  i_req_valid,
  output logic [N_REQ-1:0]  o_req_ready,
  input  logic [N_REQ*DW-1:0] i_req_data,
  output logic [DW-1:0]     o_act_in,
  input  logic [DW-1:0]     i_act_out,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DW-1:0]     o_res_data,
  output logic [IDW-1:0]    o_res_id,
  output logic              o_busy
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int ICW = $clog2(ACT_LAT + 1);
  localparam int SCW = $clog2(FIFO_DEPTH + ACT_LAT + 1) + 1;

  logic [IDW-1:0]   r_rr_ptr;
  act_tag_t         r_tag [ACT_LAT];
  logic [ICW-1:0]   r_inflight;

  logic [N_REQ-1:0] w_rot;
  int               w_off;
  logic [IDW-1:0]   w_grant;
  logic             w_can_issue;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [FCW-1:0]   w_fifo_count;
  logic [DW+IDW-1:0] w_rdata;

  // Credits come from registered counts only, so a pop frees a slot one cycle later
  assign w_can_issue = (SCW'(w_fifo_count) + SCW'(r_inflight)) < SCW'(FIFO_DEPTH);
  assign w_issue     = (|i_req_valid) && w_can_issue;

  // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins
  always_comb begin
    w_rot = N_REQ'({i_req_valid, i_req_valid} >> r_rr_ptr);
    w_off = 0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = j;
    end
    w_grant = IDW'((int'(r_rr_ptr) + w_off) % N_REQ);
  end

  always_comb begin
    o_act_in    = '0;
    o_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_issue && (w_grant == IDW'(i))) begin
        o_act_in       = i_req_data[i*DW +: DW];
        o_req_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= IDW'((int'(w_grant) + 1) % N_REQ);
    end
  end

  // Tag pipe mirrors the activation unit latency; bubbles carry vld=0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < ACT_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= '{vld: w_issue, id: w_grant};
      for (int s = 1; s < ACT_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign w_push = r_tag[ACT_LAT-1].vld;
  assign w_pop  = o_res_valid && i_res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= r_inflight + ICW'(w_issue) - ICW'(w_push);
    end
  end

  act_result_fifo #(
    .WIDTH (DW + IDW),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({i_act_out, r_tag[ACT_LAT-1].id}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_fifo_count)
  );

  assign o_res_valid = (w_fifo_count != '0);
  assign o_res_data  = w_rdata[IDW +: DW];
  assign o_res_id    = w_rdata[IDW-1:0];
  assign o_busy      = (r_inflight != '0) || (w_fifo_count != '0);

endmodule
`default_nettype wire
